// File: rtl/product_acc_pkg.sv
// Shared types and helpers for the product accumulator: FSM state encoding,
// accumulator width derivation and a wide round/shift/saturate reference function.
package product_acc_pkg;

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } acc_state_t;

  // Wide enough for any sum the default configuration can produce plus rounding.
  localparam int MODEL_W = 256;

  typedef struct packed {
    logic               sat;
    logic [MODEL_W-1:0] data;
  } rss_t;

  function automatic int calc_acc_w(input int prod_w, input int n_terms);
    return prod_w + $clog2(n_terms) + 1;
  endfunction

  function automatic rss_t round_shift_sat(input logic [MODEL_W-1:0] sum,
                                           input int shift, input int out_w);
    logic [MODEL_W-1:0] rnd;
    logic [MODEL_W-1:0] r;
    logic [MODEL_W-1:0] limit;
    rss_t               res;
    rnd      = (shift > 0) ? (MODEL_W'(1) << (shift - 1)) : '0;
    r        = (sum + rnd) >> shift;
    limit    = (MODEL_W'(1) << out_w) - MODEL_W'(1);
    res.sat  = (r > limit);
    res.data = res.sat ? limit : r;
    return res;
  endfunction

endpackage

// File: rtl/product_accumulator_if.sv
// Product-in / result-out bus of the product accumulator.
// Both channels: a transfer happens on a rising clk edge where valid && ready;
// the sender holds valid and its payload stable until that edge.
interface product_accumulator_if #(
  parameter int PROD_W = 128,
  parameter int OUT_W  = 64
);
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_prod;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;
  logic              out_sat;

  modport master (
    output in_valid, in_prod, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_prod, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/product_accumulator_round_sat.sv
// Combinational round-half-up, right shift by SHIFT and clamp to OUT_W bits.
module round_sat #(
  parameter int ACC_W = 131,
  parameter int SHIFT = 64,
  parameter int OUT_W = 64
) (
  input  logic [ACC_W-1:0] sum,
  output logic [OUT_W-1:0] data,
  output logic             sat
);
  localparam int Q_W = ACC_W - SHIFT;
  // Half of one output LSB; zero when no shift is applied.
  localparam logic [ACC_W-1:0] RND = (ACC_W'(1) << SHIFT) >> 1;

  logic [Q_W-1:0] shifted;

  assign shifted = Q_W'((sum + RND) >> SHIFT);

  generate
    if (Q_W > OUT_W) begin : g_clamp
      assign sat  = |shifted[Q_W-1:OUT_W];
      assign data = sat ? '1 : shifted[OUT_W-1:0];
    end else begin : g_fits
      assign sat  = 1'b0;
      assign data = OUT_W'(shifted);
    end
  endgenerate
endmodule

// File: rtl/product_accumulator.sv
// Accumulates N_TERMS products, then presents the rounded, shifted, saturated sum
// and holds it until the consumer takes it.
module product_accumulator
  import product_acc_pkg::*;
#(
  parameter int PROD_W  = 128,
  parameter int N_TERMS = 4,
  parameter int SHIFT   = 64,
  parameter int OUT_W   = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  product_accumulator_if.slave  bus,
  output acc_state_t            debug_state
);
  localparam int ACC_W = calc_acc_w(PROD_W, N_TERMS);
  localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

  acc_state_t       state_q, state_d;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] sum;
  logic [CNT_W-1:0] cnt_q;
  logic [OUT_W-1:0] data_q, rs_data;
  logic             sat_q, rs_sat;
  logic             in_fire, out_fire, last_term;

  assign sum       = acc_q + ACC_W'(bus.in_prod);
  assign last_term = (cnt_q == LAST_CNT);

  round_sat #(.ACC_W(ACC_W), .SHIFT(SHIFT), .OUT_W(OUT_W)) u_round_sat (
    .sum  (sum),
    .data (rs_data),
    .sat  (rs_sat)
  );

  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    in_fire       = 1'b0;
    out_fire      = 1'b0;
    case (state_q)
      ACC: begin
        bus.in_ready = 1'b1;
        in_fire      = bus.in_valid;
        if (in_fire && last_term) state_d = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        out_fire      = bus.out_ready;
        if (out_fire) state_d = ACC;
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ACC;
    else        state_q <= state_d;
  end

  // The partial sum is only cleared once the result has been handed over.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      data_q <= '0;
      sat_q  <= 1'b0;
    end else begin
      if (in_fire && !last_term) begin
        acc_q <= sum;
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (in_fire && last_term) begin
        data_q <= rs_data;
        sat_q  <= rs_sat;
      end
      if (out_fire) begin
        acc_q <= '0;
        cnt_q <= '0;
      end
    end
  end

  assign bus.out_data = data_q;
  assign bus.out_sat  = sat_q;
  assign debug_state  = state_q;
endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench for product_accumulator: directed vector table, handshake
// corner sequences and randomized groups scored against a behavioural model.
module tb_product_accumulator;
  import product_acc_pkg::*;

  localparam int PROD_W  = 128;
  localparam int OUT_W   = 64;
  localparam int N_TERMS = 4;
  localparam int SHIFT   = 64;

  localparam logic [127:0] P64  = 128'h0000_0000_0000_0001_0000_0000_0000_0000;
  localparam logic [127:0] P63  = 128'h0000_0000_0000_0000_8000_0000_0000_0000;
  localparam logic [127:0] P63M = 128'h0000_0000_0000_0000_7FFF_FFFF_FFFF_FFFF;
  localparam logic [127:0] SQ   = 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001;
  localparam logic [127:0] HI   = 128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000;
  localparam logic [63:0]  ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic       clk;
  logic       rst_n;
  acc_state_t debug_state;

  product_accumulator_if #(.PROD_W(PROD_W), .OUT_W(OUT_W)) bus ();

  product_accumulator #(
    .PROD_W(PROD_W), .N_TERMS(N_TERMS), .SHIFT(SHIFT), .OUT_W(OUT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .debug_state (debug_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [64:0] exp_q[$];

  typedef struct {
    string        name;
    logic [127:0] p [4];
    logic [63:0]  exp_data;
    logic         exp_sat;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push(input logic [127:0] p);
    int waited = 0;
    bus.in_valid = 1'b1;
    bus.in_prod  = p;
    while (!bus.in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) check("push_timeout", 128'(bus.in_ready), 128'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic collect(input string name, input logic [63:0] exp_data, input logic exp_sat);
    int waited = 0;
    logic [63:0] held;
    while (!bus.out_valid && waited < 50) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check({name, "_valid"}, 128'(bus.out_valid), 128'd1);
    check({name, "_data"}, 128'(bus.out_data), 128'(exp_data));
    check({name, "_sat"}, 128'(bus.out_sat), 128'(exp_sat));
    held = bus.out_data;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({name, "_reready"}, 128'({bus.in_ready, bus.out_valid}), 128'b10);
    check({name, "_held"}, 128'(bus.out_data), 128'(held));
  endtask

  function automatic logic [127:0] rand_prod();
    logic [127:0] v;
    v = {$urandom, $urandom, $urandom, $urandom};
    case ($urandom_range(0, 4))
      0: return v;
      1: return v >> $urandom_range(1, 127);
      2: return '0;
      3: return P63 + 128'($urandom_range(0, 2)) - 128'd1;
      default: return P64 * 128'($urandom_range(0, 7));
    endcase
  endfunction

  initial begin
    logic [255:0] model_sum;
    rss_t         res;
    logic [64:0]  e;

    vecs[0] = '{"basic",       '{P64, P64, P64, P64}, 64'd4, 1'b0};
    vecs[1] = '{"round_up",    '{P63, 0, 0, 0},       64'd1, 1'b0};
    vecs[2] = '{"round_down",  '{P63M, 0, 0, 0},      64'd0, 1'b0};
    vecs[3] = '{"saturate",    '{SQ, SQ, SQ, SQ},     ONES,  1'b1};
    vecs[4] = '{"zeros",       '{0, 0, 0, 0},         64'd0, 1'b0};
    vecs[5] = '{"three_half",  '{P64, P64, P64, P63}, 64'd4, 1'b0};
    vecs[6] = '{"two_half",    '{P64, P64, P63, 0},   64'd3, 1'b0};
    vecs[7] = '{"max_no_sat",  '{HI, 0, 0, 0},        ONES,  1'b0};
    vecs[8] = '{"just_over",   '{HI, P63, 0, 0},      ONES,  1'b1};

    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_prod = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_in_ready", 128'(bus.in_ready), 128'd1);
    check("reset_out_valid", 128'(bus.out_valid), 128'd0);
    check("reset_out_data", 128'(bus.out_data), 128'd0);
    check("reset_out_sat", 128'(bus.out_sat), 128'd0);
    check("reset_state", 128'(debug_state), 128'(ACC));

    // ---------------- directed table ----------------
    for (int i = 0; i < 9; i++) begin
      for (int j = 0; j < 4; j++) begin
        push(vecs[i].p[j]);
        check({vecs[i].name, "_lat"}, 128'(bus.out_valid), (j == 3) ? 128'd1 : 128'd0);
      end
      collect(vecs[i].name, vecs[i].exp_data, vecs[i].exp_sat);
    end

    // ---------------- backpressure ----------------
    for (int j = 0; j < 4; j++) push(P64);
    bus.in_valid = 1'b1;
    bus.in_prod = P64;
    for (int c = 0; c < 5; c++) begin
      check("bp_in_ready", 128'(bus.in_ready), 128'd0);
      check("bp_out_data", 128'(bus.out_data), 128'd4);
      check("bp_state", 128'(debug_state), 128'(DONE));
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    collect("bp_first", 64'd4, 1'b0);
    for (int j = 0; j < 4; j++) push(P64);
    collect("bp_second", 64'd4, 1'b0);

    // ---------------- reset mid-accumulation ----------------
    push(P64);
    push(P64);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", 128'(bus.out_valid), 128'd0);
    check("rst_mid_in_ready", 128'(bus.in_ready), 128'd1);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int j = 0; j < 4; j++) push(P64);
    collect("rst_mid_after", 64'd4, 1'b0);

    // ---------------- reset with a pending result ----------------
    for (int j = 0; j < 4; j++) push(SQ);
    #2 rst_n = 1'b0;
    #1;
    check("rst_done_out_valid", 128'(bus.out_valid), 128'd0);
    check("rst_done_in_ready", 128'(bus.in_ready), 128'd1);
    check("rst_done_out_sat", 128'(bus.out_sat), 128'd0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int j = 0; j < 4; j++) push(P63);
    collect("rst_done_after", 64'd2, 1'b0);

    // ---------------- randomized groups vs. model ----------------
    for (int g = 0; g < 30; g++) begin
      logic [127:0] p;
      model_sum = '0;
      for (int j = 0; j < N_TERMS; j++) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
        p = rand_prod();
        push(p);
        model_sum = model_sum + 256'(p);
      end
      res = round_shift_sat(model_sum, SHIFT, OUT_W);
      exp_q.push_back({res.sat, res.data[63:0]});
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
        check("rand_hold_ready", 128'(bus.in_ready), 128'd0);
      end
      e = exp_q.pop_front();
      collect("rand", e[63:0], e[64]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Downstream stage of the 64x64=128 unsigned multiplier. Consumes one 128-bit product per valid/ready handshake and accumulates N_TERMS products into a wide register.
- Then applies round-half-up, right-shifts by SHIFT, saturates to OUT_W bits and presents the result with a valid/ready handshake.
- Used to form p-bit local-field dot products from successive weight*state products.

Parameters:
- PROD_W, 128, product input width (matches multiplier output).
- N_TERMS, 4, products per accumulation (>=1).
- SHIFT, 64, fixed-point right shift applied to the final sum (0..PROD_W-1).
- OUT_W, 64, result width.
- ACC_W, PROD_W+$clog2(N_TERMS)+1, accumulator width; derived, never overridden.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  product valid.
- in_ready  output  1  block can accept a product.
- in_prod  input  PROD_W  unsigned product.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_data  output  OUT_W  rounded, shifted, saturated sum.
- out_sat  output  1  out_data was clamped this result.

Behaviour:
- Interface: one clock clk; reset rst_n asynchronous, active-low.
- Reset values: state=ACC, acc=0, cnt=0, in_ready=1, out_valid=0, out_data=0, out_sat=0. Reset takes effect immediately and discards any partial sum or pending result.
- All arithmetic unsigned. acc is ACC_W bits and cannot overflow for N_TERMS maximal products plus the rounding constant.
- States:
  - ACC: in_ready=1, out_valid=0. On in_valid&&in_ready with cnt<N_TERMS-1: acc<=acc+in_prod, cnt<=cnt+1.
  - ACC, last term (cnt==N_TERMS-1): sum=acc+in_prod; compute result from sum; register out_data/out_sat; go to DONE.
  - DONE: in_ready=0, out_valid=1. out_data/out_sat held stable until out_ready. On out_valid&&out_ready: acc<=0, cnt<=0, out_valid<=0, go to ACC. in_ready is high again in the next cycle.
- Result computation:
  - r = (sum + (SHIFT>0 ? 1<<(SHIFT-1) : 0)) >> SHIFT.
  - If r > 2^OUT_W-1: out_data = all ones, out_sat=1. Else out_data = r[OUT_W-1:0], out_sat=0.
- Latency: out_valid rises in the cycle after the last product handshake.
- Throughput: N_TERMS+1 cycles minimum per result (no overlap of accumulate and output hold).
- Backpressure: out_ready low holds DONE indefinitely. in_ready stays 0, so no product is lost or absorbed. in_valid while in_ready=0 is ignored; the upstream holds it.
- N_TERMS=1: every accepted product goes directly to DONE.
- in_prod=0 terms still count toward N_TERMS.
- out_data keeps its last value after the handshake (not cleared) until the next result is registered. Only out_valid qualifies it.

Decomposition:
- Shared package product_acc_pkg holds:
  - state enum {ACC, DONE};
  - function for ACC_W derivation;
  - round/shift/saturate function, also used by the bench reference model.
- One natural sub-module: round_sat (combinational, sum -> out_data/out_sat), parameterised by ACC_W, SHIFT, OUT_W.
- Handshake/FSM and accumulator stay in the top.

Test Plan:
- Basic sum: defaults; four products 2^64 (a=b=2^32), out_ready=1 -> out_data=4, out_sat=0; out_valid high exactly 1 cycle after 4th accept.
- Rounding up: products 2^63,0,0,0 -> out_data=1.
- Rounding down: products 2^63-1,0,0,0 -> out_data=0.
- Saturation: four products (2^64-1)^2 -> out_data=64'hFFFF_FFFF_FFFF_FFFF, out_sat=1.
- Backpressure: result 4 pending, out_ready=0 for 5 cycles, in_valid=1 with new products -> in_ready=0 throughout, out_data stable at 4. Release -> next four 2^64 products give 4, not a larger sum.
- Reset mid-operation: accept two 2^64 products, pulse rst_n low between clock edges -> out_valid=0, in_ready=1 immediately. Then four 2^64 products -> out_data=4 (not 6).
